mem_arbiter: RTL

Single-port memory arbiter that shares the 256-byte unified memory between three requesters:
- instruction fetch (two-byte reads),
- execution-unit data load/store (one byte),
- debug/loader port (one byte).

It sits in cpu_top between the memory array and its clients and sequences every memory access. The debug port has absolute priority. Fetch and data alternate round-robin when both are pending.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified-memory arbiter.
//   requester_t  - identity of a memory client (fetch, data, debug)
//   arb_state_t  - sequencing states of one memory transaction
package mem_arb_pkg;

  typedef enum logic [1:0] {
    REQ_FETCH,
    REQ_DATA,
    REQ_DEBUG
  } requester_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAP0,
    CAP1,
    DONE
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: client and memory-side signals of the unified-memory arbiter.
//   fetch_*  - instruction fetch (two-byte read)
//   data_*   - execution-unit load/store (one byte)
//   dbg_*    - debug/loader load/store (one byte)
//   mem_*    - single-port memory bus (address/strobe/wdata registered by arbiter)
// Modports: slave = arbiter side, master = clients + memory side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic                  fetch_req;
  logic [ADDR_W-1:0]     fetch_addr;
  logic                  fetch_done;
  logic [2*DATA_W-1:0]   fetch_instr;

  logic                  data_req;
  logic                  data_we;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_done;
  logic [DATA_W-1:0]     data_rdata;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [ADDR_W-1:0]     dbg_addr;
  logic [DATA_W-1:0]     dbg_wdata;
  logic                  dbg_done;
  logic [DATA_W-1:0]     dbg_rdata;

  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_done, fetch_instr,
    input  data_req, data_we, data_addr, data_wdata,
    output data_done, data_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_done, dbg_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_done, fetch_instr,
    output data_req, data_we, data_addr, data_wdata,
    input  data_done, data_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_done, dbg_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/arb_pick.sv
// arb_pick: combinational request picker.
//   fetch_req, data_req, dbg_req - pending request levels
//   last_grant                   - last fetch/data winner (debug never recorded)
//   valid                        - any request pending
//   pick                         - winning requester
// Debug always wins; a fetch/data tie goes to whichever was not granted last.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       dbg_req,
  input  requester_t last_grant,
  output logic       valid,
  output requester_t pick
);

  always_comb begin
    valid = fetch_req | data_req | dbg_req;
    pick  = REQ_FETCH;
    if (dbg_req) begin
      pick = REQ_DEBUG;
    end else if (fetch_req && data_req) begin
      pick = (last_grant == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    end else if (data_req) begin
      pick = REQ_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences every access to the single-port unified memory.
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low
//   bus    - client request/done/result ports and the memory bus (slave side)
//   busy   - high whenever a transaction is in progress
// One transaction at a time: IDLE -> ISSUE -> CAP0 [-> CAP1 for fetch] -> DONE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  arb_state_t          state, state_nx;
  requester_t          owner, last_grant, pick;
  logic                pick_valid;
  logic                pick_we;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;

  logic                op_we;
  logic [DATA_W-1:0]   byte0;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_we_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [2*DATA_W-1:0] fetch_instr_q;
  logic [DATA_W-1:0]   data_rdata_q;
  logic [DATA_W-1:0]   dbg_rdata_q;

  arb_pick u_pick (
    .fetch_req  (bus.fetch_req),
    .data_req   (bus.data_req),
    .dbg_req    (bus.dbg_req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .pick       (pick)
  );

  // Operands of the winning requester; fetch is read-only.
  always_comb begin
    pick_addr  = bus.fetch_addr;
    pick_we    = 1'b0;
    pick_wdata = '0;
    case (pick)
      REQ_DATA: begin
        pick_addr  = bus.data_addr;
        pick_we    = bus.data_we;
        pick_wdata = bus.data_wdata;
      end
      REQ_DEBUG: begin
        pick_addr  = bus.dbg_addr;
        pick_we    = bus.dbg_we;
        pick_wdata = bus.dbg_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_valid) state_nx = ISSUE;
      ISSUE:   state_nx = CAP0;
      CAP0:    state_nx = (owner == REQ_FETCH) ? CAP1 : DONE;
      CAP1:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner         <= REQ_FETCH;
      last_grant    <= REQ_FETCH;
      op_we         <= 1'b0;
      byte0         <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      fetch_instr_q <= '0;
      data_rdata_q  <= '0;
      dbg_rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner       <= pick;
            op_we       <= pick_we;
            mem_addr_q  <= pick_addr;
            mem_we_q    <= pick_we;
            mem_wdata_q <= pick_wdata;
            if (pick != REQ_DEBUG) last_grant <= pick;
          end
        end
        ISSUE: begin
          mem_we_q <= 1'b0;
          // The memory has a one-cycle read latency, so the second fetch
          // address must already be on the bus during CAP0 for its byte
          // to arrive in CAP1.
          if (owner == REQ_FETCH) mem_addr_q <= mem_addr_q + ADDR_W'(1);
        end
        CAP0: begin
          case (owner)
            REQ_FETCH: byte0        <= bus.mem_rdata;
            REQ_DATA:  data_rdata_q <= op_we ? '0 : bus.mem_rdata;
            default:   dbg_rdata_q  <= op_we ? '0 : bus.mem_rdata;
          endcase
        end
        CAP1: fetch_instr_q <= {byte0, bus.mem_rdata};
        default: ;
      endcase
    end
  end

  assign busy            = (state != IDLE);
  assign bus.fetch_done  = (state == DONE) && (owner == REQ_FETCH);
  assign bus.data_done   = (state == DONE) && (owner == REQ_DATA);
  assign bus.dbg_done    = (state == DONE) && (owner == REQ_DEBUG);
  assign bus.fetch_instr = fetch_instr_q;
  assign bus.data_rdata  = data_rdata_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule
